// File: rtl/dcache_ctrl.sv
// dcache_ctrl: lookup, store-hit, writeback and refill sequencer
// driving one two-way cache_table for a single LSU port.
module dcache_ctrl #(
  parameter int NUM_WAY        = 2,
  parameter int BYTES_PER_LINE = 16,
  parameter int NUM_LINE       = 256,
  parameter int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
  parameter int INDEX_WIDTH    = $clog2(NUM_LINE),
  parameter int TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int WORDS          = BYTES_PER_LINE / 4,
  parameter int BANK_NUM_WIDTH = $clog2(WORDS),
  parameter int BITS_PER_LINE  = BYTES_PER_LINE * 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_wstrb,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      rd_req,
  input  logic                      rd_rdy,
  output logic [31:0]               rd_addr,
  input  logic                      ret_valid,
  input  logic [31:0]               ret_data,
  output logic                      wr_req,
  input  logic                      wr_rdy,
  output logic [31:0]               wr_addr,
  output logic [BITS_PER_LINE-1:0]  wr_data,
  output logic [INDEX_WIDTH-1:0]    tbl_index,
  output logic [TAG_WIDTH-1:0]      tbl_tag,
  output logic [BANK_NUM_WIDTH-1:0] tbl_bank_num,
  output logic [NUM_WAY-1:0]        tbl_sel_way,
  output logic                      tbl_write,
  output logic [NUM_WAY-1:0]        tbl_write_way,
  output logic                      tbl_tv_write,
  output logic [31:0]               tbl_write_data,
  output logic [3:0]                tbl_write_strb,
  output logic                      tbl_d_write,
  input  logic [NUM_WAY-1:0]        tbl_hit_way,
  input  logic [31:0]               tbl_rdata,
  input  logic [BITS_PER_LINE-1:0]  tbl_read_line,
  input  logic [TAG_WIDTH-1:0]      tbl_read_tag,
  input  logic                      tbl_dirty
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, WB, RD, REFILL, DONE
  } state_e;

  localparam int IHI = OFFSET_WIDTH + INDEX_WIDTH - 1;

  state_e                    state_q, state_d;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [INDEX_WIDTH-1:0]    idx_q;
  logic [BANK_NUM_WIDTH-1:0] bank_q;
  logic                      wr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic [NUM_WAY-1:0]        rr_q, rr_d;
  logic [BANK_NUM_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]               rword_q, rword_d;
  logic [31:0]               merged;
  logic                      accept;
  logic                      hit;
  logic                      unused_addr;

  assign unused_addr = ^req_addr[1:0];
  assign hit = |tbl_hit_way;

  always_comb begin
    merged = ret_data;
    for (int b = 0; b < 4; b++) begin
      if (wr_q && cnt_q == bank_q && wstrb_q[b])
        merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    rword_d        = rword_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    rd_req         = 1'b0;
    rd_addr        = '0;
    wr_req         = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    tbl_index      = '0;
    tbl_tag        = '0;
    tbl_bank_num   = '0;
    tbl_sel_way    = '0;
    tbl_write      = 1'b0;
    tbl_write_way  = '0;
    tbl_tv_write   = 1'b0;
    tbl_write_data = '0;
    tbl_write_strb = '0;
    tbl_d_write    = 1'b0;
    accept         = 1'b0;
    if (!reset) begin
      tbl_index    = idx_q;
      tbl_tag      = tag_q;
      tbl_bank_num = bank_q;
      unique case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_d = LOOKUP;
        end
        LOOKUP: begin
          // victim dirty bit must be read here for MISS to see it
          tbl_sel_way = rr_q;
          if (hit && !wr_q) begin
            resp_valid = 1'b1;
            resp_rdata = tbl_rdata;
            req_ready  = 1'b1;
            state_d    = req_valid ? LOOKUP : IDLE;
          end else if (hit) begin
            tbl_write      = 1'b1;
            tbl_write_way  = tbl_hit_way;
            tbl_write_data = wdata_q;
            tbl_write_strb = wstrb_q;
            tbl_d_write    = 1'b1;
            resp_valid     = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = MISS;
          end
        end
        MISS: begin
          tbl_sel_way = rr_q;
          state_d     = tbl_dirty ? WB : RD;
        end
        WB: begin
          tbl_sel_way = rr_q;
          wr_req      = 1'b1;
          wr_addr     = {tbl_read_tag, idx_q, {OFFSET_WIDTH{1'b0}}};
          wr_data     = tbl_read_line;
          if (wr_rdy) state_d = RD;
        end
        RD: begin
          tbl_sel_way = rr_q;
          rd_req      = 1'b1;
          rd_addr     = {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};
          if (rd_rdy) begin
            state_d = REFILL;
            cnt_d   = '0;
          end
        end
        REFILL: begin
          tbl_sel_way  = rr_q;
          tbl_bank_num = cnt_q;
          if (ret_valid) begin
            tbl_write      = 1'b1;
            tbl_write_way  = rr_q;
            tbl_tv_write   = 1'b1;
            tbl_write_data = merged;
            tbl_write_strb = 4'hF;
            tbl_d_write    = wr_q;
            if (cnt_q == bank_q) rword_d = ret_data;
            if (cnt_q == BANK_NUM_WIDTH'(WORDS - 1)) begin
              state_d = DONE;
              cnt_d   = '0;
              rr_d    = {rr_q[NUM_WAY-2:0], rr_q[NUM_WAY-1]};
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          resp_valid = 1'b1;
          resp_rdata = wr_q ? '0 : rword_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
      accept = req_valid & req_ready;
      if (accept) begin
        tbl_index    = req_addr[IHI:OFFSET_WIDTH];
        tbl_tag      = req_addr[31:IHI+1];
        tbl_bank_num = req_addr[OFFSET_WIDTH-1:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= NUM_WAY'(1);
      cnt_q   <= '0;
      rword_q <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      bank_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      rword_q <= rword_d;
      if (accept) begin
        tag_q   <= req_addr[31:IHI+1];
        idx_q   <= req_addr[IHI:OFFSET_WIDTH];
        bank_q  <= req_addr[OFFSET_WIDTH-1:2];
        wr_q    <= req_wr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench with a behavioural
// two-way table and a line-granular memory responder.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_wstrb;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic rd_req, rd_rdy;
  logic [31:0] rd_addr;
  logic ret_valid, rv_mem, rv_spur;
  logic [31:0] ret_data;
  logic wr_req, wr_rdy;
  logic [31:0] wr_addr;
  logic [127:0] wr_data;
  logic [7:0] tbl_index;
  logic [19:0] tbl_tag;
  logic [1:0] tbl_bank_num;
  logic [1:0] tbl_sel_way;
  logic tbl_write;
  logic [1:0] tbl_write_way;
  logic tbl_tv_write;
  logic [31:0] tbl_write_data;
  logic [3:0] tbl_write_strb;
  logic tbl_d_write;
  logic [1:0] tbl_hit_way;
  logic [31:0] tbl_rdata;
  logic [127:0] tbl_read_line;
  logic [19:0] tbl_read_tag;
  logic tbl_dirty;

  always #5 clk = ~clk;
  assign ret_valid = rv_mem | rv_spur;

  dcache_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_rdy(wr_rdy),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .tbl_index(tbl_index), .tbl_tag(tbl_tag),
    .tbl_bank_num(tbl_bank_num), .tbl_sel_way(tbl_sel_way),
    .tbl_write(tbl_write), .tbl_write_way(tbl_write_way),
    .tbl_tv_write(tbl_tv_write),
    .tbl_write_data(tbl_write_data),
    .tbl_write_strb(tbl_write_strb),
    .tbl_d_write(tbl_d_write),
    .tbl_hit_way(tbl_hit_way), .tbl_rdata(tbl_rdata),
    .tbl_read_line(tbl_read_line),
    .tbl_read_tag(tbl_read_tag), .tbl_dirty(tbl_dirty)
  );

  logic any_out;
  assign any_out = |{req_ready, resp_valid, resp_rdata,
    rd_req, rd_addr, wr_req, wr_addr, wr_data,
    tbl_index, tbl_tag, tbl_bank_num, tbl_sel_way,
    tbl_write, tbl_write_way, tbl_tv_write,
    tbl_write_data, tbl_write_strb, tbl_d_write};

  // behavioural table: registered reads, old data on collision
  logic [31:0] tm_data [2][256][4];
  logic [19:0] tm_tag [2][256];
  logic tm_v [2][256];
  logic tm_d [2][256];
  logic tm_clr;
  logic [1:0] tm_hit;
  logic [31:0] tm_r;
  logic [127:0] tm_line;
  logic [19:0] tm_rt;
  logic tm_dt;
  logic sw;

  always_comb begin
    tm_hit = '0;
    tm_r = '0;
    for (int w = 0; w < 2; w++) begin
      if (tm_v[w][tbl_index] && tm_tag[w][tbl_index] == tbl_tag) begin
        tm_hit[w] = 1'b1;
        tm_r = tm_r | tm_data[w][tbl_index][tbl_bank_num];
      end
    end
    sw = tbl_sel_way[1];
    tm_line = {tm_data[sw][tbl_index][3], tm_data[sw][tbl_index][2],
               tm_data[sw][tbl_index][1], tm_data[sw][tbl_index][0]};
    tm_rt = tm_tag[sw][tbl_index];
    tm_dt = (|tbl_sel_way) && tm_d[sw][tbl_index];
  end

  always @(posedge clk) begin
    tbl_hit_way <= tm_hit;
    tbl_rdata <= tm_r;
    tbl_read_line <= tm_line;
    tbl_read_tag <= tm_rt;
    tbl_dirty <= tm_dt;
    if (tm_clr) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 256; i++) begin
          tm_v[w][i] <= 1'b0;
          tm_d[w][i] <= 1'b0;
        end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (tbl_write && tbl_write_way[w]) begin
          for (int b = 0; b < 4; b++)
            if (tbl_write_strb[b])
              tm_data[w][tbl_index][tbl_bank_num][8*b +: 8]
                <= tbl_write_data[8*b +: 8];
          tm_d[w][tbl_index] <= tbl_d_write;
          if (tbl_tv_write) begin
            tm_tag[w][tbl_index] <= tbl_tag;
            tm_v[w][tbl_index] <= 1'b1;
          end
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct { logic [31:0] d; int cyc; } exp_t;
  typedef struct { logic [31:0] a; logic [127:0] l; } wb_t;
  exp_t sb_q[$];
  logic [31:0] rd_exp_q[$];
  wb_t wr_exp_q[$];

  // monitor: every response pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL resp_extra: got rdata %0h want no response",
                   resp_rdata);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", 128'(resp_rdata), 128'(e.d));
          if (e.cyc >= 0) chk("resp_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  function automatic logic [31:0] rw(input logic [31:0] a,
                                     input int i);
    return 32'h90 + {24'h0, a[15:12], 4'h0} + 32'(i);
  endfunction

  int ret_n = 4;
  int sent = 0;
  int bursts = 0;

  // memory responder: checks request addresses, holds, then serves
  initial begin
    logic [31:0] a;
    wb_t wb;
    rv_mem = 1'b0;
    ret_data = '0;
    rd_rdy = 1'b0;
    wr_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (rd_req) begin
        a = rd_addr;
        bursts++;
        sent = 0;
        if (rd_exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rd_extra: got rd_addr %0h want none", a);
        end else begin
          chk("rd_addr", 128'(a), 128'(rd_exp_q.pop_front()));
        end
        repeat (2) @(negedge clk);
        chk("rd_hold", 128'({rd_req, rd_addr}), 128'({1'b1, a}));
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int i = 0; i < ret_n; i++) begin
          rv_mem = 1'b1;
          ret_data = rw(a, i);
          @(negedge clk);
          rv_mem = 1'b0;
          sent = i + 1;
          if (i == 1) @(negedge clk);
        end
      end else if (wr_req) begin
        a = wr_addr;
        if (wr_exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL wr_extra: got wr_addr %0h want none", a);
        end else begin
          wb = wr_exp_q.pop_front();
          chk("wr_addr", 128'(a), 128'(wb.a));
          chk("wr_data", wr_data, wb.l);
        end
        repeat (2) @(negedge clk);
        chk("wr_hold", 128'({wr_req, wr_addr}), 128'({1'b1, a}));
        wr_rdy = 1'b1;
        @(negedge clk);
        wr_rdy = 1'b0;
      end
    end
  end

  int last_hs = 0;

  task automatic issue(input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] ed, input bit lat,
                       input bit push);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_wdata = wd;
    req_wstrb = st;
    #1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL req_timeout %0h: got ready 0 want 1", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    last_hs = cyc;
    if (push) sb_q.push_back('{ed, lat ? cyc : -1});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int t0, b0, n;
    reset = 1'b1;
    tm_clr = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rv_spur = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("rst_outs", 128'(any_out), 128'(0));
    reset = 1'b0;
    tm_clr = 1'b0;
    #1 chk("rst_ready", 128'(req_ready), 128'(1));

    @(negedge clk);
    rv_spur = 1'b1;
    #1 chk("ret_idle", 128'({tbl_write, req_ready}), 128'(2'b01));
    @(negedge clk);
    rv_spur = 1'b0;

    rd_exp_q.push_back(32'h1000);
    issue(1'b0, 32'h1000, 0, 4'h0, 32'hA0, 1'b0, 1'b1);
    issue(1'b0, 32'h1004, 0, 4'h0, 32'hA1, 1'b1, 1'b1);
    issue(1'b1, 32'h1008, 32'hDEADBEEF, 4'h3, 0, 1'b1, 1'b1);
    chk("st_hit_ctl", 128'({tbl_write, tbl_write_way, tbl_tv_write,
        tbl_d_write, tbl_bank_num, tbl_write_strb, req_ready}),
        128'({1'b1, 2'b01, 1'b0, 1'b1, 2'd2, 4'h3, 1'b0}));
    chk("st_hit_data", 128'(tbl_write_data), 128'(32'hDEADBEEF));
    issue(1'b0, 32'h1008, 0, 4'h0, 32'h0000BEEF, 1'b1, 1'b1);

    rd_exp_q.push_back(32'h2000);
    issue(1'b1, 32'h2004, 32'h55, 4'hF, 0, 1'b0, 1'b1);
    issue(1'b0, 32'h2004, 0, 4'h0, 32'h55, 1'b1, 1'b1);
    chk("stmiss_way1", 128'({tm_v[1][0], tm_d[1][0], tm_tag[1][0]}),
        128'({1'b1, 1'b1, 20'h2}));
    issue(1'b0, 32'h2008, 0, 4'h0, 32'hB2, 1'b1, 1'b1);

    wr_exp_q.push_back('{32'h1000,
      {32'hA3, 32'h0000BEEF, 32'hA1, 32'hA0}});
    rd_exp_q.push_back(32'h3000);
    issue(1'b0, 32'h3000, 0, 4'h0, 32'hC0, 1'b0, 1'b1);

    issue(1'b0, 32'h3004, 0, 4'h0, 32'hC1, 1'b1, 1'b1);
    t0 = last_hs;
    issue(1'b0, 32'h300C, 0, 4'h0, 32'hC3, 1'b1, 1'b1);
    issue(1'b0, 32'h2004, 0, 4'h0, 32'h55, 1'b1, 1'b1);
    issue(1'b0, 32'h3008, 0, 4'h0, 32'hC2, 1'b1, 1'b1);
    chk("b2b_span", 128'(last_hs - t0), 128'(3));
    chk("wb_way0", 128'({tm_d[0][0], tm_tag[0][0], tm_tag[1][0]}),
        128'({1'b0, 20'h3, 20'h2}));

    ret_n = 2;
    b0 = bursts;
    rd_exp_q.push_back(32'h5010);
    issue(1'b0, 32'h5010, 0, 4'h0, 0, 1'b0, 1'b0);
    n = 0;
    while (!(bursts == b0 + 1 && sent == 2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("abort_words", 128'(sent), 128'(2));
    #2 reset = 1'b1;
    #1 chk("rst_mid_outs", 128'(any_out), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    ret_n = 4;
    #1 chk("rst_mid_idle", 128'({req_ready, rd_req}), 128'(2'b10));

    rd_exp_q.push_back(32'h6020);
    issue(1'b0, 32'h6020, 0, 4'h0, 32'hF0, 1'b0, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    chk("rd_q_empty", 128'(rd_exp_q.size()), 128'(0));
    chk("wr_q_empty", 128'(wr_exp_q.size()), 128'(0));
    chk("post_rst_way0", 128'({tm_v[0][2], tm_tag[0][2]}),
        128'({1'b1, 20'h6}));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Miss-handling controller that sequences one two-way `cache_table` instance on behalf of a single CPU load/store port. It performs lookup, store-hit write, dirty-victim writeback and line refill against a line-granular memory interface. It sits between the LSU and the AXI bridge, and owns every write/select input of the table.

## Interface
- NUM_WAY, 2, ways; victim selection is round-robin over this count
- BYTES_PER_LINE, 16, line size; WORDS = BYTES_PER_LINE/4
- NUM_LINE, 256, sets; OFFSET/INDEX/TAG widths derive as in the table
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  CPU request present
- req_ready  out  1  request accepted when valid&ready
- req_wr  in  1  1=store, 0=load
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_wstrb  in  4  store byte enables
- resp_valid  out  1  one-cycle pulse, exactly one per accepted request
- resp_rdata  out  32  load data, valid with resp_valid; 0 for stores
- rd_req  out  1  refill request, held until rd_rdy
- rd_rdy  in  1  refill request accepted
- rd_addr  out  32  {tag,index,OFFSET zeros}
- ret_valid  in  1  one refill word, bank 0 first, ascending
- ret_data  in  32  refill word
- wr_req  out  1  writeback request, held until wr_rdy
- wr_rdy  in  1  writeback accepted (whole line in one beat)
- wr_addr  out  32  {victim tag,index,OFFSET zeros}
- wr_data  out  BITS_PER_LINE  victim line
- tbl_index  out  INDEX_WIDTH  to table index, write_index, d_index
- tbl_tag  out  TAG_WIDTH  to table tag and tag_write; v_write is tied 1
- tbl_bank_num  out  BANK_NUM_WIDTH  to table bank_num and write_bank_num
- tbl_sel_way  out  NUM_WAY  one-hot victim; to table read_way and d_way
- tbl_write  out  1  table write enable
- tbl_write_way  out  NUM_WAY  to table write_way and d_write_way
- tbl_tv_write  out  1  tag_v_write_way = tbl_tv_write ? tbl_write_way : 0
- tbl_write_data  out  32  table write_data
- tbl_write_strb  out  4  table write_strb
- tbl_d_write  out  1  dirty value written
- tbl_hit_way, tbl_rdata, tbl_read_line, tbl_read_tag, tbl_dirty  in  table widths  table read results (next-cycle)

## Operation
- States: IDLE, LOOKUP, MISS, WB, RD, REFILL, DONE.
- Request registers capture tag, index, bank, wr, wdata and wstrb on every handshake.
- tbl_index and tbl_bank_num carry the request-address fields during the accept cycle, the latched fields otherwise, and the refill counter during REFILL.
- IDLE: req_ready=1. On handshake, go to LOOKUP.
- LOOKUP, hit, load: resp_valid=1, resp_rdata=tbl_rdata. req_ready=1, so back-to-back loads stay in LOOKUP and otherwise return to IDLE.
- LOOKUP, hit, store: write=1, write_way=hit_way, bank=req bank, data=req_wdata, strb=req_wstrb, d_write=1, tv_write=0, resp_valid=1, req_ready=0. Next state IDLE.
- LOOKUP, miss: go to MISS.
- MISS: tbl_sel_way = rr pointer (reset 1'b1 one-hot). If tbl_dirty, go to WB; else go to RD.
- WB: wr_req=1 with wr_addr and wr_data from tbl_read_tag/tbl_read_line. On wr_rdy, go to RD. The table index is held, so the read outputs stay stable.
- RD: rd_req=1. On rd_rdy, go to REFILL with cnt=0.
- REFILL: each ret_valid writes bank cnt: write=1, write_way=victim, strb=4'hF, tv_write=1, d_write=req_wr.
  - When cnt equals the req bank and the request is a store, merge req_wdata per req_wstrb into ret_data before writing.
  - When cnt equals the req bank, capture the load word (unmerged ret_data).
  - On cnt=WORDS-1, go to DONE and rotate rr left.
- DONE: resp_valid=1 with the captured word, req_ready=0. Next state IDLE.
- Reset: state IDLE, rr=one-hot way0, cnt=0. Every output is 0 during and after reset except req_ready=1 once in IDLE. A reset mid-refill abandons the line; the memory side drops the burst.

## Timing
- Load hit: 1 cycle from handshake to resp_valid. Throughput is 1 load/cycle.
- Store hit: resp in LOOKUP. Next accept is 1 cycle later, so the write never shares the BRAM port with a read.
- Clean miss: resp 3 + rd wait + WORDS refill cycles + 1 after handshake. A dirty miss adds WB + wr wait.
- ret_valid may gap. ret_valid outside REFILL is ignored.
- rd_req/wr_req stay high until their ready, and addresses stay stable meanwhile.

## Test plan
- Load 0x1000 on an empty cache -> rd_addr=0x1000; 4 refill words 0xA0..0xA3; resp_rdata=0xA0; reload 0x1004 -> 1-cycle hit, 0xA1.
- Store 0x1008 data 0xDEADBEEF strb 0x3 after the refill above -> table write bank2 strb 0x3; subsequent load returns 0xA2 with its low half replaced by 0xBEEF.
- Fill both ways of index 0 with dirty lines, load tag 3 at index 0 -> wr_req with way0's tag and line, then rd_req; rr toggles.
- Store miss at 0x2004, strb 0xF, data 0x55 -> refill bank1 written as 0x55, dirty=1; resp_valid pulses once.
- Back-to-back load hits on 4 addresses -> 4 consecutive resp_valid cycles.
- Assert reset during REFILL after 2 words -> outputs 0, IDLE next cycle; next request starts a fresh lookup.
